// File: rtl/ex_hazard_ctrl.sv
// Hazard/forwarding controller for the 16-bit pipelined EX stage: operand forwarding,
// load-use stall sequencing and taken-branch flush. Define EX_HAZARD_PERF_EN to add stall/flush counters.
module ex_hazard_ctrl #(
    parameter int REG_BITS     = 3,
    parameter int LOAD_LATENCY = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic                id_uses_rs,
    input  logic                id_uses_rt,
    input  logic [REG_BITS-1:0] ex_rs,
    input  logic [REG_BITS-1:0] ex_rt,
    input  logic [REG_BITS-1:0] ex_rd,
    input  logic                ex_memread,
    input  logic [REG_BITS-1:0] mem_rd,
    input  logic                mem_regwrite,
    input  logic [REG_BITS-1:0] wb_rd,
    input  logic                wb_regwrite,
    input  logic                branch_taken,
    output logic [1:0]          forward_a,
    output logic [1:0]          forward_b,
    output logic                pc_write,
    output logic                ifid_write,
    output logic                idex_bubble,
    output logic                flush_ifid,
    output logic                flush_idex,
    output logic                flush_exmem,
    output logic                stalled
`ifdef EX_HAZARD_PERF_EN
    ,
    output logic [15:0]         stall_cycles,
    output logic [15:0]         flush_events
`endif
);

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

    // The first stall cycle is spent in RUN, so the counter covers the remaining ones minus one.
    localparam logic [2:0] STALL_LOAD = (LOAD_LATENCY > 1) ? 3'(LOAD_LATENCY - 2) : 3'd0;

    state_t     stateReg;
    logic [2:0] cntReg;
    logic       loadUse;

    logic [1:0][REG_BITS-1:0] exSrc;
    logic [1:0][1:0]          fwdSel;

    assign exSrc[0] = ex_rs;
    assign exSrc[1] = ex_rt;

    // MEM result is younger than WB, so it wins; r0 is hard-wired zero and never forwarded.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwdSel[gi] =
                (!reset_n)                                                        ? 2'b00 :
                (mem_regwrite && (mem_rd != '0) && (mem_rd == exSrc[gi]))         ? 2'b10 :
                (wb_regwrite  && (wb_rd  != '0) && (wb_rd  == exSrc[gi]))         ? 2'b01 :
                                                                                    2'b00;
        end
    endgenerate

    assign forward_a = fwdSel[0];
    assign forward_b = fwdSel[1];

    assign loadUse = ex_memread && (ex_rd != '0) &&
                     ((id_uses_rs && (ex_rd == id_rs)) || (id_uses_rt && (ex_rd == id_rt)));

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        if (reset_n) begin
            if (branch_taken) begin
                flush_ifid  = 1'b1;
                flush_idex  = 1'b1;
                flush_exmem = 1'b1;
            end else if ((stateReg == STALL) || loadUse) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    assign stalled = (stateReg == STALL);

    // Once stalling, the hazard is not re-checked: the load has moved on and only the count matters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateReg <= RUN;
            cntReg   <= 3'd0;
        end else if (branch_taken) begin
            stateReg <= RUN;
            cntReg   <= 3'd0;
        end else begin
            case (stateReg)
                RUN: begin
                    if (loadUse && (LOAD_LATENCY > 1)) begin
                        stateReg <= STALL;
                        cntReg   <= STALL_LOAD;
                    end
                end
                STALL: begin
                    if (cntReg == 3'd0) begin
                        stateReg <= RUN;
                    end else begin
                        cntReg <= cntReg - 3'd1;
                    end
                end
                default: begin
                    stateReg <= RUN;
                    cntReg   <= 3'd0;
                end
            endcase
        end
    end

`ifdef EX_HAZARD_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= 16'h0000;
            flush_events <= 16'h0000;
        end else begin
            if (!pc_write && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'h0001;
            end
            if (branch_taken && (flush_events != 16'hFFFF)) begin
                flush_events <= flush_events + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: two instances (LOAD_LATENCY 1 and 3) share one set of inputs.
module tb_ex_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [2:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rs, id_uses_rt, ex_memread, mem_regwrite, wb_regwrite, branch_taken;

    logic [1:0] fa1, fb1, fa3, fb3;
    logic       pc1, ifid1, bub1, fi1, fd1, fe1, st1;
    logic       pc3, ifid3, bub3, fi3, fd3, fe3, st3;
`ifdef EX_HAZARD_PERF_EN
    logic [15:0] sc1, fev1, sc3, fev3;
`endif

    int nChecks = 0;
    int nErrors = 0;

    // {pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex, flush_exmem}
    localparam logic [5:0] RUNV   = 6'b110000;
    localparam logic [5:0] STALLV = 6'b001000;
    localparam logic [5:0] FLUSHV = 6'b110111;

    logic [5:0] ctrl1, ctrl3;
    assign ctrl1 = {pc1, ifid1, bub1, fi1, fd1, fe1};
    assign ctrl3 = {pc3, ifid3, bub3, fi3, fd3, fe3};

    always #5 clock = ~clock;

    ex_hazard_ctrl #(.REG_BITS(3), .LOAD_LATENCY(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .branch_taken(branch_taken),
        .forward_a(fa1), .forward_b(fb1), .pc_write(pc1), .ifid_write(ifid1),
        .idex_bubble(bub1), .flush_ifid(fi1), .flush_idex(fd1), .flush_exmem(fe1),
        .stalled(st1)
`ifdef EX_HAZARD_PERF_EN
        , .stall_cycles(sc1), .flush_events(fev1)
`endif
    );

    ex_hazard_ctrl #(.REG_BITS(3), .LOAD_LATENCY(3)) u_dut3 (
        .clock(clock), .reset_n(reset_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .branch_taken(branch_taken),
        .forward_a(fa3), .forward_b(fb3), .pc_write(pc3), .ifid_write(ifid3),
        .idex_bubble(bub3), .flush_ifid(fi3), .flush_idex(fd3), .flush_exmem(fe3),
        .stalled(st3)
`ifdef EX_HAZARD_PERF_EN
        , .stall_cycles(sc3), .flush_events(fev3)
`endif
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
        id_uses_rs = 0; id_uses_rt = 0; ex_memread = 0; mem_regwrite = 0; wb_regwrite = 0;
        branch_taken = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic loadUseRs();
        ex_memread = 1; ex_rd = 3'd2; id_rs = 3'd2; id_uses_rs = 1;
    endtask

    initial begin
        idle();
        reset_n = 0;
        // Hazard and forwarding conditions present while in reset must be masked.
        loadUseRs();
        mem_regwrite = 1; mem_rd = 3'd3; ex_rs = 3'd3;
        #12;
        check("reset ctrl1", 16'(ctrl1), 16'(RUNV));
        check("reset ctrl3", 16'(ctrl3), 16'(RUNV));
        check("reset stalled3", 16'(st3), 16'd0);
        check("reset fwd_a", 16'(fa1), 16'd0);
        idle();
        step();
        reset_n = 1;
        step();
`ifdef EX_HAZARD_PERF_EN
        check("perf reset stall", sc3, 16'h0000);
        check("perf reset flush", fev3, 16'h0000);
`endif

        // Forwarding: MEM over WB, then WB alone, then r0 never forwarded.
        mem_regwrite = 1; mem_rd = 3'd3; wb_regwrite = 1; wb_rd = 3'd3; ex_rs = 3'd3; ex_rt = 3'd5;
        #1;
        check("fwd mem prio a", 16'(fa1), 16'd2);
        check("fwd b none", 16'(fb1), 16'd0);
        check("fwd no stall", 16'(ctrl1), 16'(RUNV));
        mem_regwrite = 0;
        #1;
        check("fwd wb a", 16'(fa1), 16'd1);
        wb_rd = 3'd5; mem_regwrite = 1; mem_rd = 3'd5;
        #1;
        check("fwd mem b", 16'(fb3), 16'd2);
        check("fwd a after wb moved", 16'(fa3), 16'd0);
        mem_regwrite = 0;
        #1;
        check("fwd wb b", 16'(fb3), 16'd1);
        mem_regwrite = 1; mem_rd = 3'd0; wb_regwrite = 1; wb_rd = 3'd0; ex_rs = 3'd0; ex_rt = 3'd0;
        #1;
        check("fwd r0 a", 16'(fa1), 16'd0);
        check("fwd r0 b", 16'(fb1), 16'd0);
        idle();

        // Non-hazards: rd=r0, or matching register not actually read.
        ex_memread = 1; ex_rd = 3'd0; id_rs = 3'd0; id_uses_rs = 1;
        #1;
        check("nohz r0", 16'(ctrl1), 16'(RUNV));
        ex_rd = 3'd4; id_rs = 3'd4; id_uses_rs = 0;
        #1;
        check("nohz unused rs", 16'(ctrl1), 16'(RUNV));
        idle();
        step();

        // Load-use via rs: LL=1 stalls one cycle, LL=3 stalls three.
        loadUseRs();
        #1;
        check("lu c1 ctrl1", 16'(ctrl1), 16'(STALLV));
        check("lu c1 ctrl3", 16'(ctrl3), 16'(STALLV));
        check("lu c1 stalled1", 16'(st1), 16'd0);
        check("lu c1 stalled3", 16'(st3), 16'd0);
        step();
        idle();
        #1;
        check("lu c2 ctrl1", 16'(ctrl1), 16'(RUNV));
        check("lu c2 stalled1", 16'(st1), 16'd0);
        check("lu c2 ctrl3", 16'(ctrl3), 16'(STALLV));
        check("lu c2 stalled3", 16'(st3), 16'd1);
        step();
        check("lu c3 ctrl3", 16'(ctrl3), 16'(STALLV));
        check("lu c3 stalled3", 16'(st3), 16'd1);
        step();
        check("lu c4 ctrl3", 16'(ctrl3), 16'(RUNV));
        check("lu c4 stalled3", 16'(st3), 16'd0);
`ifdef EX_HAZARD_PERF_EN
        check("perf stall3 count", sc3, 16'd3);
        check("perf stall1 count", sc1, 16'd1);
`endif

        // Load-use via rt.
        ex_memread = 1; ex_rd = 3'd6; id_rt = 3'd6; id_uses_rt = 1; id_rs = 3'd6; id_uses_rs = 0;
        #1;
        check("lu rt ctrl1", 16'(ctrl1), 16'(STALLV));
        step();
        idle();
        step();
        step();
        check("lu rt done3", 16'(st3), 16'd0);

        // Branch taken in the second stall cycle aborts the stall.
        loadUseRs();
        step();
        idle();
        branch_taken = 1;
        #1;
        check("br stall ctrl3", 16'(ctrl3), 16'(FLUSHV));
        check("br stall stalled3", 16'(st3), 16'd1);
        check("br ctrl1", 16'(ctrl1), 16'(FLUSHV));
        step();
        branch_taken = 0;
        #1;
        check("br after stalled3", 16'(st3), 16'd0);
        check("br after ctrl3", 16'(ctrl3), 16'(RUNV));
`ifdef EX_HAZARD_PERF_EN
        check("perf flush count", fev3, 16'd1);
`endif

        // Branch together with a fresh hazard in RUN: branch wins, no stall follows.
        loadUseRs();
        branch_taken = 1;
        #1;
        check("br+hz ctrl3", 16'(ctrl3), 16'(FLUSHV));
        step();
        idle();
        #1;
        check("br+hz next stalled3", 16'(st3), 16'd0);
        check("br+hz next ctrl3", 16'(ctrl3), 16'(RUNV));

        // Asynchronous reset in the middle of a stall.
        loadUseRs();
        step();
        check("rst pre stalled3", 16'(st3), 16'd1);
        #2;
        reset_n = 0;
        #1;
        check("rst mid stalled3", 16'(st3), 16'd0);
        check("rst mid ctrl3", 16'(ctrl3), 16'(RUNV));
`ifdef EX_HAZARD_PERF_EN
        check("rst perf stall3", sc3, 16'h0000);
        check("rst perf flush3", fev3, 16'h0000);
`endif
        idle();
        step();
        reset_n = 1;
        step();
        check("rst release stalled3", 16'(st3), 16'd0);

`ifdef EX_HAZARD_PERF_EN
        // Hold a hazard on the LL=1 instance so pc_write stays low every cycle.
        loadUseRs();
        for (int i = 0; i < 65540; i++) step();
        check("perf saturate stall1", sc1, 16'hFFFF);
        idle();
`endif

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
